// File: rtl/demux_sched.sv
// demux_sched: registered 1:4 demux scheduler, addressed or round-robin destination choice.
// Define DEMUX_SCHED_CNT_EN to add per-output saturating delivery counters (cnt, cnt_clr).
module demux_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_rr,
    input  logic [3:0]        en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              drop
`ifdef DEMUX_SCHED_CNT_EN
    ,
    output logic [4*CNT_W-1:0] cnt,
    input  logic               cnt_clr
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t r_state, w_next;
    logic [DATA_W-1:0] r_data;
    logic [1:0] r_sel, r_rr_ptr, w_rr_dest, w_dest;
    logic r_drop, w_deliver, w_accept, w_store, w_drop;
    // first enabled output at or after the pointer, wrapping mod 4
    assign w_rr_dest = en[r_rr_ptr]         ? r_rr_ptr :
                       en[r_rr_ptr + 2'd1] ? r_rr_ptr + 2'd1 :
                       en[r_rr_ptr + 2'd2] ? r_rr_ptr + 2'd2 : r_rr_ptr + 2'd3;
    assign w_deliver = (r_state == FULL) & out_ready[r_sel];
    assign in_ready  = ((r_state == EMPTY) | w_deliver) & ~(mode_rr & (en == 4'b0000));
    assign w_accept  = in_valid & in_ready;
    assign w_dest    = mode_rr ? w_rr_dest : in_dest;
    assign w_store   = w_accept & (mode_rr | en[in_dest]);
    assign w_drop    = w_accept & ~mode_rr & ~en[in_dest];
    assign out_valid = (r_state == FULL) ? 4'b0001 << r_sel : 4'b0000;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign drop      = r_drop;
    always_comb begin
        w_next = r_state;
        if (w_store)
            w_next = FULL;
        else if (w_deliver)
            w_next = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_data   <= '0;
            r_sel    <= '0;
            r_drop   <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_drop;
            if (w_store) begin
                r_data <= in_data;
                r_sel  <= w_dest;
            end
            if (w_store & mode_rr)
                r_rr_ptr <= w_rr_dest + 2'd1;
        end
    end
`ifdef DEMUX_SCHED_CNT_EN
    genvar i;
    for (i = 0; i < 4; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt <= '0;
            else if (cnt_clr)
                r_cnt <= '0;
            else if (w_deliver && r_sel == 2'(i) && ~&r_cnt)
                r_cnt <= r_cnt + CNT_W'(1);
        end
        assign cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif
endmodule
